// File: rtl/mouse_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mouse_arb_pkg : payload field map, saturating merge, FSM states   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package mouse_arb_pkg;

  localparam int BTN_MSB     = 2;
  localparam int BTN_LSB     = 0;
  localparam int ALWAYS1_BIT = 3;
  localparam int XSGN_BIT    = 4;
  localparam int YSGN_BIT    = 5;
  localparam int XOVR_BIT    = 6;
  localparam int YOVR_BIT    = 7;
  localparam int X_LSB       = 8;
  localparam int X_MSB       = 15;
  localparam int Y_LSB       = 16;
  localparam int Y_MSB       = 23;
  localparam int STROBE_BIT  = 24;

  typedef logic [23:0] payload_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GAP  = 1'b1
  } arb_state_e;

  // Signed 9-bit add clamped to -256..+255; overflow shows as s[9] != s[8].
  function automatic logic [8:0] sat9_add(input logic [8:0] a, input logic [8:0] b);
    logic [9:0] s;
    s = {a[8], a} + {b[8], b};
    if (s[9] != s[8]) begin
      sat9_add = s[9] ? 9'h100 : 9'h0FF;
    end else begin
      sat9_add = s[8:0];
    end
  endfunction

  function automatic payload_t merge_pkt(input payload_t old_p, input payload_t new_p);
    logic [8:0] x;
    logic [8:0] y;
    payload_t   r;
    x = sat9_add({old_p[XSGN_BIT], old_p[X_MSB:X_LSB]}, {new_p[XSGN_BIT], new_p[X_MSB:X_LSB]});
    y = sat9_add({old_p[YSGN_BIT], old_p[Y_MSB:Y_LSB]}, {new_p[YSGN_BIT], new_p[Y_MSB:Y_LSB]});
    r                  = '0;
    r[Y_MSB:Y_LSB]     = y[7:0];
    r[X_MSB:X_LSB]     = x[7:0];
    r[YOVR_BIT]        = 1'b0;
    r[XOVR_BIT]        = 1'b0;
    r[YSGN_BIT]        = y[8];
    r[XSGN_BIT]        = x[8];
    r[ALWAYS1_BIT]     = 1'b1;
    r[BTN_MSB:BTN_LSB] = new_p[BTN_MSB:BTN_LSB];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mouse_src_arb_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mouse_src_arb_if : source packet buses and forwarded packet bus   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface mouse_src_arb_if;
  logic [24:0] src0_mouse;
  logic [24:0] src1_mouse;
  logic [24:0] ps2_mouse_out;
  logic        owner;
  logic        busy;

  modport slave (
    input  src0_mouse,
    input  src1_mouse,
    output ps2_mouse_out,
    output owner,
    output busy
  );

  modport master (
    output src0_mouse,
    output src1_mouse,
    input  ps2_mouse_out,
    input  owner,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/mouse_arb_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mouse_arb_fifo : 2-entry packet buffer, merges into newest on full|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module mouse_arb_fifo
  import mouse_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     push_i,
  input  payload_t data_i,
  input  logic     pop_i,
  output logic     empty_o,
  output payload_t head_o
);

  localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);

  payload_t   entry0_q, entry0_d;
  payload_t   entry1_q, entry1_d;
  logic [1:0] count_q, count_d;
  logic       w_pop;

  assign w_pop   = pop_i && (count_q != 2'd0);
  assign empty_o = (count_q == 2'd0);
  assign head_o  = entry0_q;

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    case ({push_i, w_pop})
      2'b11: begin
        // Pop and push together shift the queue; no merge needed.
        if (count_q == FULL_CNT) begin
          entry0_d = entry1_q;
          entry1_d = data_i;
        end else begin
          entry0_d = data_i;
        end
      end
      2'b10: begin
        if (count_q == 2'd0) begin
          entry0_d = data_i;
          count_d  = 2'd1;
        end else if (count_q == 2'd1) begin
          entry1_d = data_i;
          count_d  = 2'd2;
        end else begin
          entry1_d = merge_pkt(entry1_q, data_i);
        end
      end
      2'b01: begin
        entry0_d = entry1_q;
        count_d  = count_q - 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mouse_src_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mouse_src_arb : two-source PS/2 mouse packet arbiter with pacing  |
// | Option: MOUSE_ARB_BTN_LOCK_EN enables button-hold ownership lock. |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module mouse_src_arb
  import mouse_arb_pkg::*;
#(
  parameter int GAP_TICKS  = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ce,
  mouse_src_arb_if.slave  bus
);

  localparam logic [11:0] GAP_LAST = 12'(GAP_TICKS - 1);

  logic [24:0] w_src   [2];
  payload_t    w_head  [2];
  logic [1:0]  w_push;
  logic [1:0]  w_empty;
  logic [1:0]  w_pop;
  logic [1:0]  w_elig;
  logic        w_sel;

  logic        primed_q;
  logic [1:0]  tog_q;
  arb_state_e  state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [24:0] out_q, out_d;
  logic        owner_q, owner_d;
  logic        rr_q, rr_d;
`ifdef MOUSE_ARB_BTN_LOCK_EN
  logic        lock_q, lock_d;
`endif

  assign w_src[0] = bus.src0_mouse;
  assign w_src[1] = bus.src1_mouse;

  // History is captured on the first clock after reset so a strobe level
  // present at release is never mistaken for a new packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      primed_q <= 1'b0;
      tog_q    <= 2'b00;
    end else begin
      primed_q <= 1'b1;
      tog_q    <= {w_src[1][STROBE_BIT], w_src[0][STROBE_BIT]};
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign w_push[gi] = primed_q && (w_src[gi][STROBE_BIT] != tog_q[gi]);

      mouse_arb_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (w_push[gi]),
        .data_i  (w_src[gi][23:0]),
        .pop_i   (w_pop[gi]),
        .empty_o (w_empty[gi]),
        .head_o  (w_head[gi])
      );
    end
  endgenerate

  always_comb begin
    w_elig = ~w_empty;
`ifdef MOUSE_ARB_BTN_LOCK_EN
    if (lock_q) begin
      w_elig = owner_q ? (~w_empty & 2'b10) : (~w_empty & 2'b01);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    w_pop   = 2'b00;
    w_sel   = (&w_elig) ? rr_q : w_elig[1];
`ifdef MOUSE_ARB_BTN_LOCK_EN
    lock_d  = lock_q;
`endif
    case (state_q)
      IDLE: begin
        if (|w_elig) begin
          w_pop[w_sel] = 1'b1;
          out_d        = {~out_q[STROBE_BIT], w_head[w_sel]};
          owner_d      = w_sel;
          rr_d         = ~w_sel;
`ifdef MOUSE_ARB_BTN_LOCK_EN
          lock_d       = |w_head[w_sel][BTN_MSB:BTN_LSB];
`endif
          cnt_d        = 12'd0;
          state_d      = GAP;
        end
      end
      GAP: begin
        if (ce) begin
          cnt_d = cnt_q + 12'd1;
          if (cnt_q == GAP_LAST) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 12'd0;
      out_q   <= '0;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
`ifdef MOUSE_ARB_BTN_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
`ifdef MOUSE_ARB_BTN_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  assign bus.ps2_mouse_out = out_q;
  assign bus.owner         = owner_q;
  assign bus.busy          = (state_q == GAP);

endmodule
`default_nettype wire

// File: tb/tb_mouse_src_arb.sv
`default_nettype none
// Directed bench for mouse_src_arb with GAP_TICKS=4; forwarded packets are
// captured on toggle of bit 24 and compared against hand-computed values.
module tb_mouse_src_arb;

  logic clk;
  logic reset_n;
  logic ce;
  int   checks;
  int   errors;
  int   busy_cnt;
  logic prev_tog;
  logic [24:0] fwd_q [$];

  mouse_src_arb_if bus ();

  mouse_src_arb #(
    .GAP_TICKS  (4),
    .FIFO_DEPTH (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.busy) busy_cnt = busy_cnt + 1;
    if (!reset_n) begin
      prev_tog = bus.ps2_mouse_out[24];
    end else if (bus.ps2_mouse_out[24] != prev_tog) begin
      prev_tog = bus.ps2_mouse_out[24];
      fwd_q.push_back({bus.owner, bus.ps2_mouse_out[23:0]});
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send(input int src, input logic [23:0] p);
    @(negedge clk);
    #1;
    if (src == 0) bus.src0_mouse = {~bus.src0_mouse[24], p};
    else          bus.src1_mouse = {~bus.src1_mouse[24], p};
  endtask

  task automatic send_both(input logic [23:0] p0, input logic [23:0] p1);
    @(negedge clk);
    #1;
    bus.src0_mouse = {~bus.src0_mouse[24], p0};
    bus.src1_mouse = {~bus.src1_mouse[24], p1};
  endtask

  task automatic wait_fwd(output logic ok, output logic [24:0] v);
    ok = 1'b0;
    v  = '0;
    for (int i = 0; i < 200; i++) begin
      if (fwd_q.size() != 0) begin
        v  = fwd_q.pop_front();
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic expect_fwd(input string name, input logic [24:0] exp);
    logic        ok;
    logic [24:0] v;
    wait_fwd(ok, v);
    checks++;
    if (!ok || v !== exp) begin
      errors++;
      $display("FAIL %s: got {owner,payload}=%h (seen=%0d) expected %h", name, v, ok, exp);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ce = 1'b1;
    bus.src0_mouse = {1'b1, 24'h123456};
    bus.src1_mouse = 25'h0;
    #23;
    checks++;
    if (bus.ps2_mouse_out !== 25'h0) begin
      errors++; $display("FAIL reset_out: got %h expected 0", bus.ps2_mouse_out);
    end
    checks++;
    if (bus.owner !== 1'b0) begin
      errors++; $display("FAIL reset_owner: got %b expected 0", bus.owner);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    tick(10);
    checks++;
    if (fwd_q.size() != 0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_no_spurious: got %0d packets busy=%b expected 0", fwd_q.size(), bus.busy);
    end
  endtask

  task automatic test_single();
    busy_cnt = 0;
    send(0, 24'h000508);
    expect_fwd("single_payload", {1'b0, 24'h000508});
    checks++;
    if (bus.ps2_mouse_out[24] !== 1'b1) begin
      errors++; $display("FAIL single_toggle: got %b expected 1", bus.ps2_mouse_out[24]);
    end
    tick(10);
    checks++;
    if (busy_cnt != 4) begin
      errors++; $display("FAIL single_busy: got %0d busy cycles expected 4", busy_cnt);
    end
    checks++;
    if (fwd_q.size() != 0) begin
      errors++; $display("FAIL single_once: got %0d extra packets expected 0", fwd_q.size());
    end
  endtask

  task automatic test_merge_pos();
    send(1, 24'h000108);
    expect_fwd("merge_lead", {1'b1, 24'h000108});
    ce = 1'b0;
    for (int i = 0; i < 3; i++) send(1, 24'h006408);
    tick(1);
    ce = 1'b1;
    expect_fwd("merge_first", {1'b1, 24'h006408});
    expect_fwd("merge_200", {1'b1, 24'h00C808});
  endtask

  task automatic test_sat_pos();
    tick(8);
    send(1, 24'h000108);
    expect_fwd("sat_lead", {1'b1, 24'h000108});
    ce = 1'b0;
    for (int i = 0; i < 5; i++) send(1, 24'h006408);
    tick(1);
    ce = 1'b1;
    expect_fwd("sat_first", {1'b1, 24'h006408});
    expect_fwd("sat_255", {1'b1, 24'h00FF08});
  endtask

  task automatic test_sat_neg();
    tick(8);
    send(1, 24'h000108);
    expect_fwd("neg_lead", {1'b1, 24'h000108});
    ce = 1'b0;
    send(1, 24'h000208);
    send(1, 24'h003818);
    send(1, 24'h009CD8);
    tick(1);
    ce = 1'b1;
    expect_fwd("neg_first", {1'b1, 24'h000208});
    expect_fwd("neg_m256", {1'b1, 24'h000018});
  endtask

  task automatic test_round_robin();
    tick(8);
    send(1, 24'h000308);
    expect_fwd("rr_lead", {1'b1, 24'h000308});
    ce = 1'b0;
    send_both(24'h001008, 24'h002008);
    send_both(24'h001108, 24'h002108);
    tick(1);
    ce = 1'b1;
    expect_fwd("rr_0", {1'b0, 24'h001008});
    expect_fwd("rr_1", {1'b1, 24'h002008});
    expect_fwd("rr_2", {1'b0, 24'h001108});
    expect_fwd("rr_3", {1'b1, 24'h002108});
  endtask

  task automatic test_lock();
    tick(8);
    send(0, 24'h000209);
    expect_fwd("lock_lead", {1'b0, 24'h000209});
    ce = 1'b0;
    send_both(24'h000309, 24'h004008);
    send(0, 24'h000408);
    tick(1);
    ce = 1'b1;
`ifdef MOUSE_ARB_BTN_LOCK_EN
    expect_fwd("lock_held0", {1'b0, 24'h000309});
    expect_fwd("lock_held1", {1'b0, 24'h000408});
    expect_fwd("lock_release", {1'b1, 24'h004008});
`else
    expect_fwd("nolock_0", {1'b1, 24'h004008});
    expect_fwd("nolock_1", {1'b0, 24'h000309});
    expect_fwd("nolock_2", {1'b0, 24'h000408});
`endif
  endtask

  task automatic test_reset_mid_gap();
    tick(8);
    send(1, 24'h000508);
    expect_fwd("rst_lead", {1'b1, 24'h000508});
    ce = 1'b0;
    send_both(24'h001208, 24'h002208);
    send_both(24'h001308, 24'h002308);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.ps2_mouse_out !== 25'h0) begin
      errors++; $display("FAIL rst_mid_out: got %h expected 0", bus.ps2_mouse_out);
    end
    checks++;
    if (bus.owner !== 1'b0) begin
      errors++; $display("FAIL rst_mid_owner: got %b expected 0", bus.owner);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy);
    end
    tick(3);
    reset_n = 1'b1;
    ce = 1'b1;
    tick(20);
    checks++;
    if (fwd_q.size() != 0 || bus.ps2_mouse_out !== 25'h0) begin
      errors++; $display("FAIL rst_mid_quiet: got %0d packets out=%h expected 0", fwd_q.size(), bus.ps2_mouse_out);
    end
    send(0, 24'h000608);
    expect_fwd("rst_mid_new", {1'b0, 24'h000608});
    checks++;
    if (bus.ps2_mouse_out[24] !== 1'b1) begin
      errors++; $display("FAIL rst_mid_toggle: got %b expected 1", bus.ps2_mouse_out[24]);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    busy_cnt = 0;
    prev_tog = 1'b0;
    test_reset();
    test_single();
    test_merge_pos();
    test_sat_pos();
    test_sat_neg();
    test_round_robin();
    test_lock();
    test_reset_mid_gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mouse_src_arb.md
Name: mouse_src_arb

Overview:
- Shares the single Mac mouse quadrature path between two pointing sources: the host PS/2 mouse and the on-screen/joystick pointer emulation.
- Each source presents a 25-bit PS/2-style packet bus with a toggle strobe on bit 24.
- The block buffers packets per source, merges them on overflow, arbitrates round-robin with button-hold ownership, and re-emits one packet at a time with paced spacing.
- Its output feeds the quadrature emulator's ps2_mouse input unchanged.

Parameters:
- GAP_TICKS, 64: minimum ce pulses between forwarded packets (1..4095).
- FIFO_DEPTH, 2: per-source buffer entries; fixed at 2, parameter is documentation only.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable for gap pacing
- src0_mouse  in  25  PS/2 packet bus, source 0 (host mouse): [24] toggle strobe, [23:16] Y, [15:8] X, [7:0] status byte
- src1_mouse  in  25  PS/2 packet bus, source 1 (emulated pointer), same format
- ps2_mouse_out  out  25  forwarded packet bus, same format
- owner  out  1  source of last forwarded packet
- busy  out  1  high while in GAP state

Behaviour:
- Reset values:
  - ps2_mouse_out = 0, owner = 0, busy = 0.
  - FIFOs empty; RR pointer selects src0 first; lock clear.
  - Strobe history registers load the current bit 24 of each input, so no spurious packet is seen after reset.
- Strobe detect: new packet when srcN[24] differs from its registered copy. Push happens the cycle after the edge (1-cycle latency).
- FIFO: 2 entries of 24-bit payload per source.
- Overflow (push while full, no same-cycle pop): merge into the newest entry.
  - X = sat9(oldX + newX), Y = sat9(oldY + newY).
  - Each operand is 9-bit signed {sign, byte}; result saturates to -256..+255.
  - Result bytes and sign bits 4/5 are rebuilt from the sum; bits 6/7 are cleared; bit 3 is forced to 1.
  - Button bits [2:0] are taken from the new packet.
- Push and pop in the same cycle: pop the oldest and append the new packet; no merge.
- State machine:
  - IDLE: the cycle a source is eligible and non-empty:
    - Pop its head.
    - Drive ps2_mouse_out[23:0] = payload and toggle ps2_mouse_out[24].
    - Set owner = source; go to GAP.
    - Forward latency: one cycle after the push is visible.
  - GAP: busy = 1; count ce pulses; after GAP_TICKS pulses return to IDLE. The packet is not re-evaluated in the same cycle as the return.
- Arbitration:
  - Both sources eligible: round-robin, with the last-served source at lowest priority.
  - Only one non-empty: serve it.
- Ownership lock (see Optional Feature):
  - Set when a forwarded packet has any of bits [2:0] = 1.
  - While set, only owner is eligible; the other source keeps buffering and merging.
  - Cleared when owner forwards a packet with bits [2:0] = 0.
- Reset mid-GAP or mid-merge: everything returns to reset state immediately. ps2_mouse_out[24] returns to 0; downstream sees one toggle, which is accepted.
- Strobe during reset deassertion: ignored, because history is preloaded.

Optional Feature:
- Macro: MOUSE_ARB_BTN_LOCK_EN.
- Defined: ownership lock as above. Prevents drags from being split by the other source.
- Undefined: lock logic is absent; pure round-robin; a button state is forwarded from whichever source is served.

Decomposition:
- Package mouse_arb_pkg holds:
  - Payload field constants: BTN[2:0], ALWAYS1 bit 3, XSGN 4, YSGN 5, XOVR 6, YOVR 7, X[15:8], Y[23:16].
  - 9-bit saturating add function and packet-merge function.
  - State enum {IDLE, GAP}.
- Sub-module: mouse_arb_fifo, the 2-entry buffer with merge-on-full, instantiated once per source.

Test Plan:
- Single packet src0 status 0x08, X=0x05, Y=0x00 with GAP_TICKS=4 and ce every cycle:
  - ps2_mouse_out[24] toggles once with payload 0x000508.
  - busy is high for 4 ce pulses.
  - owner=0.
- Overflow merge: three src1 packets X=+100 each during GAP:
  - Second forwarded packet carries X=+200 (0xC8, bit4=0).
  - Five packets of +100: merge saturates X=+255 (0xFF, sign 0).
- Negative saturation: merge X=-200 and X=-100 → X byte 0x00, XSGN=1 (-256); bits 6/7 cleared.
- Round-robin: both FIFOs loaded with 2 packets → forward order src0, src1, src0, src1.
- Lock (macro on): src0 sends status 0x09 (left down), then src1 packets arrive:
  - src1 is held until src0 forwards status 0x08.
  - Macro off: src1 is served next.
- Reset asserted mid-GAP with both FIFOs full:
  - All outputs are 0 within the same cycle.
  - After release, no forwarding until a new strobe edge arrives.
